mips_mc_control: RTL
====================

# mips_mc_control

Multicycle control FSM for the 32-bit MIPS datapath. It takes the opcode from the instruction register and drives the datapath's enables and mux selects: the `alu_src_b` and `pc_source` selects for the 4-way muxes, and the 2-way selects `iord`, `alu_src_a`, `reg_dst` and `mem_to_reg`. It also holds each memory state until the shared instruction/data memory signals completion, so memory accesses can take a variable number of cycles.

## Interface
Parameters
- `OP_W`, 6, opcode width (instr[31:26])

Ports
- `clk`  in  1  clock; all state updates on its rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `opcode`  in  OP_W  opcode field from the instruction register
- `zero`  in  1  ALU zero flag, for beq
- `mem_ready`  in  1  memory completes the current access this cycle
- `pc_en`  out  1  PC register load enable
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `ir_write`  out  1  instruction register load
- `mem_to_reg`  out  1  write-back data select: 0 = ALUOut, 1 = MDR
- `reg_dst`  out  1  destination register select: 0 = rt, 1 = rd
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = register A
- `alu_src_b`  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- `alu_op`  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct field
- `pc_source`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `illegal_op`  out  1  sticky flag: an unsupported opcode was decoded

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. Any other opcode is illegal.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BEQ, ADDIEX, ADDIWB, JUMP (4-bit encoding).
- Outputs are a Moore decode of the state. The only exceptions are `pc_en`, `ir_write` and `mem_*`-related completion, which are qualified as listed below.
- Any output not listed for a state is 0.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00; `ir_write` = `pc_en` = `mem_ready`. Moves to DECODE when `mem_ready`=1, else stays in FETCH.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (precomputes the branch target into ALUOut).
  - Next state: lw/sw → MEMADR, R-type → REXEC, beq → BEQ, j → JUMP, addi → ADDIEX.
  - Illegal opcode → FETCH and set `illegal_op`.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state: lw → MEMRD, sw → MEMWR.
- MEMRD: `mem_read`=1, `iord`=1. Moves to MEMWB on `mem_ready`, else holds.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next state FETCH.
- MEMWR: `mem_write`=1, `iord`=1. Moves to FETCH on `mem_ready`, else holds. `mem_write` stays high throughout the hold.
- REXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state RWB.
- RWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next state FETCH.
- BEQ: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01; `pc_en` = `zero`. Next state FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next state FETCH.
- JUMP: `pc_source`=10, `pc_en`=1. Next state FETCH.
- `illegal_op` is set in the DECODE cycle that sees an illegal opcode. Only reset clears it. Later legal instructions execute normally and leave the flag set.
- `opcode` is sampled only in DECODE, MEMADR and the MEMADR→lw/sw branch. The instruction register must hold `opcode` stable from FETCH completion until the instruction returns to FETCH.

## Timing
- Reset: while `rst_n`=0, state is FETCH and every output is forced to 0, including `illegal_op`.
- First fetch: FETCH outputs become active in the first cycle after `rst_n` deasserts. Release is sampled on `clk`; deassertion is assumed to be synchronised upstream.
- Reset mid-instruction: the FSM returns to FETCH immediately and asynchronously. Any `mem_write` or `reg_write` in progress drops in the same cycle.
- Cycle counts with `mem_ready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each memory wait cycle (`mem_ready`=0 in FETCH, MEMRD or MEMWR) adds one cycle. No output changes during a wait.
- `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.
- `pc_en` in FETCH and BEQ depends combinationally on `mem_ready` and `zero`. The datapath must settle these inputs before the clock edge.

## Test plan
- Reset, then hold `mem_ready`=1 with `opcode`=100011 (lw):
  - State sequence must be FETCH, DECODE, MEMADR, MEMRD, MEMWB.
  - `alu_src_b` must read 01, 11, 10 in the first three cycles.
  - `reg_write`=1 and `mem_to_reg`=1 only in cycle 5, then FETCH follows.
- sw with `mem_ready` low for 3 cycles in MEMWR:
  - `mem_write`=1 for exactly 4 cycles, `iord`=1 throughout.
  - Return to FETCH on the cycle after `mem_ready` rises.
- beq (000100):
  - With `zero`=1: `pc_en`=1 and `pc_source`=01 in cycle 3.
  - With `zero`=0: `pc_en`=0 in cycle 3.
  - In both cases FETCH follows in cycle 4.
- R-type then addi:
  - R-type: `alu_op`=10 in REXEC, `reg_dst`=1 in RWB.
  - addi: `alu_src_b`=10 in ADDIEX, `reg_dst`=0 in ADDIWB.
  - Each instruction takes 4 cycles.
- Opcode 111111:
  - DECODE → FETCH, and `illegal_op` rises one cycle later and stays set through a subsequent j.
  - During that j, `pc_source`=10 and `pc_en`=1.
  - Asserting `rst_n`=0 clears `illegal_op` immediately.
- Drop `rst_n` in MEMWB of a lw:
  - `reg_write` falls within the same cycle, with no wait for a clock edge.
  - After release, the FSM restarts at FETCH with `mem_read`=1.

Source files
------------

// File: rtl/mips_mc_control_if.sv
// Control/datapath bundle for the multicycle MIPS controller.
interface mips_mc_control_if #(
  parameter int unsigned OP_W = 6
);
  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            mem_ready;
  logic            pc_en;
  logic            iord;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write;
  logic            mem_to_reg;
  logic            reg_dst;
  logic            reg_write;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      alu_op;
  logic [1:0]      pc_source;
  logic            illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op
  );
endinterface

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: Moore decode of state, memory-ready stalls,
// sticky illegal-opcode flag. Outputs are forced low while in reset.
module mips_mc_control #(
  parameter int unsigned OP_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  mips_mc_control_if.master  bus
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_REXEC  = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BEQ    = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;

  logic       pc_en_c, iord_c, mem_read_c, mem_write_c, ir_write_c;
  logic       mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

  // State and sticky illegal flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; opcode consulted only in DECODE and MEMADR
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_REXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD :
                          (bus.opcode == OP_SW) ? S_MEMWR : S_FETCH;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore output decode, gated off while reset is asserted
  always_comb begin
    pc_en_c      = 1'b0;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_dst_c    = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    pc_source_c  = 2'b00;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read_c  = 1'b1;
          alu_src_b_c = 2'b01;
          ir_write_c  = bus.mem_ready;
          pc_en_c     = bus.mem_ready;
        end
        S_DECODE: alu_src_b_c = 2'b11;
        S_MEMADR, S_ADDIEX: begin
          alu_src_a_c = 1'b1;
          alu_src_b_c = 2'b10;
        end
        S_MEMRD: begin
          mem_read_c = 1'b1;
          iord_c     = 1'b1;
        end
        S_MEMWB: begin
          reg_write_c  = 1'b1;
          mem_to_reg_c = 1'b1;
        end
        S_MEMWR: begin
          mem_write_c = 1'b1;
          iord_c      = 1'b1;
        end
        S_REXEC: begin
          alu_src_a_c = 1'b1;
          alu_op_c    = 2'b10;
        end
        S_RWB: begin
          reg_write_c = 1'b1;
          reg_dst_c   = 1'b1;
        end
        S_BEQ: begin
          alu_src_a_c = 1'b1;
          alu_op_c    = 2'b01;
          pc_source_c = 2'b01;
          pc_en_c     = bus.zero;
        end
        S_ADDIWB: reg_write_c = 1'b1;
        S_JUMP: begin
          pc_source_c = 2'b10;
          pc_en_c     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_en      = pc_en_c;
  assign bus.iord       = iord_c;
  assign bus.mem_read   = mem_read_c;
  assign bus.mem_write  = mem_write_c;
  assign bus.ir_write   = ir_write_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.reg_write  = reg_write_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.pc_source  = pc_source_c;
  assign bus.illegal_op = illegal_q;

endmodule
